multicycle_main_ctrl: RTL
=========================

Name: multicycle_main_ctrl

Overview:
Main control FSM for the multi-cycle variant of the processor, directly upstream of the ALU control decoder. It decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback steps. It drives ALU_op (00 add, 01 sub, 10 funct-decoded) to the ALU control decoder, plus all other datapath enables and mux selects. It stalls on a memory ready handshake and enforces a stall timeout.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive cycles a memory state may wait for mem_ready before aborting; legal range 1..65535.
TO_W, 16, width of the stall counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
opcode  input  6  instr[31:26] from the instruction register.
mem_ready  input  1  memory completes the current read or write this cycle.
PC_write  output  1  unconditional PC load.
PC_write_cond  output  1  PC load qualified by ALU zero (beq).
I_or_D  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
IR_write  output  1  instruction register load.
mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut.
reg_dst  output  1  destination register: 1 = rd, 0 = rt.
reg_write  output  1  register file write enable.
ALU_src_A  output  1  0 = PC, 1 = register A.
ALU_src_B  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
ALU_op  output  2  to ALU control: 00 add, 01 sub, 10 R-format.
PC_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
illegal_op  output  1  one-cycle pulse on an unsupported opcode.
bus_error  output  1  one-cycle pulse on a memory stall timeout.

Behaviour:
- State register and stall counter reset asynchronously: state = INIT, counter = 0. Outputs are combinational from state, with the mem_ready qualification noted below.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, I_or_D=0, ALU_src_A=0, ALU_src_B=01, ALU_op=00, PC_source=00. IR_write and PC_write equal mem_ready. If mem_ready=1, go to DECODE; otherwise stay.
- DECODE: ALU_src_A=0, ALU_src_B=11, ALU_op=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EXEC
  - any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEM_ADDR: ALU_src_A=1, ALU_src_B=10, ALU_op=00. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, I_or_D=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, I_or_D=1. Wait for mem_ready, then go to FETCH.
- R_EXEC: ALU_src_A=1, ALU_src_B=00, ALU_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- ADDI_EXEC: ALU_src_A=1, ALU_src_B=10, ALU_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_op=01, PC_write_cond=1, PC_source=01. Next state FETCH.
- JUMP: PC_write=1, PC_source=10. Next state FETCH.
- Every output not listed for a state is 0. The opcode is sampled only in DECODE and MEM_ADDR.
- Stall counter (applies in FETCH, MEM_READ, MEM_WRITE):
  - Increments on each cycle with mem_ready=0; clears on leaving the state and on mem_ready=1.
  - On the cycle where the counter equals MEM_TIMEOUT-1 and mem_ready=0: bus_error=1 for that cycle, and the next state is FETCH (from MEM_READ/MEM_WRITE) or INIT (from FETCH). Counter clears.
  - In that cycle no register write or PC write occurs.
  - If mem_ready=1 on the timeout cycle, mem_ready wins: normal completion, no bus_error.
- Cycle counts with mem_ready tied to 1:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Reset asserted mid-instruction forces INIT immediately. All enables drop in the same cycle (async), with no partial writeback afterwards.

Test Plan:
- Reset release, mem_ready=1, opcode=000000: state sequence INIT, FETCH, DECODE, R_EXEC, R_WB, FETCH. ALU_op=10 only in R_EXEC; reg_write=1 with reg_dst=1 only in R_WB.
- lw (100011), mem_ready held 0 for 3 cycles in MEM_READ: mem_read=1 and I_or_D=1 for 4 cycles. MEM_WB follows, with reg_write=1 and mem_to_reg=1 for exactly 1 cycle.
- beq (000100): BRANCH shows ALU_op=01, PC_write_cond=1, PC_source=01. sw (101011): MEM_WRITE shows mem_write=1, and reg_write is never asserted.
- Opcode 111111 in DECODE: illegal_op pulses for 1 cycle, next state FETCH, and no reg_write, mem_write or PC_write occurs.
- MEM_TIMEOUT=4, mem_ready=0 throughout MEM_WRITE: bus_error pulses on the 4th stall cycle, next state FETCH. Repeat with mem_ready=1 on the 4th cycle: no bus_error.
- reset_n dropped during R_WB: all outputs 0 in the same cycle. After release: INIT, then FETCH.

Source files
------------

// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath / memory.
// The controller (master) consumes opcode and mem_ready and drives every enable and select.
interface multicycle_main_ctrl_if;
   logic [5:0] opcode;
   logic       mem_ready;

   logic       PC_write;
   logic       PC_write_cond;
   logic       I_or_D;
   logic       mem_read;
   logic       mem_write;
   logic       IR_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       ALU_src_A;
   logic [1:0] ALU_src_B;
   logic [1:0] ALU_op;
   logic [1:0] PC_source;
   logic       illegal_op;
   logic       bus_error;

   modport master (
      input  opcode,
      input  mem_ready,
      output PC_write,
      output PC_write_cond,
      output I_or_D,
      output mem_read,
      output mem_write,
      output IR_write,
      output mem_to_reg,
      output reg_dst,
      output reg_write,
      output ALU_src_A,
      output ALU_src_B,
      output ALU_op,
      output PC_source,
      output illegal_op,
      output bus_error
   );

   modport slave (
      output opcode,
      output mem_ready,
      input  PC_write,
      input  PC_write_cond,
      input  I_or_D,
      input  mem_read,
      input  mem_write,
      input  IR_write,
      input  mem_to_reg,
      input  reg_dst,
      input  reg_write,
      input  ALU_src_A,
      input  ALU_src_B,
      input  ALU_op,
      input  PC_source,
      input  illegal_op,
      input  bus_error
   );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multi-cycle processor: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and aborts a memory access that waits MEM_TIMEOUT cycles.
module multicycle_main_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   multicycle_main_ctrl_if.master bus
);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [TO_W-1:0] StallLimit = TO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      StInit,
      StFetch,
      StDecode,
      StMemAddr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StRExec,
      StRWb,
      StAddiExec,
      StAddiWb,
      StBranch,
      StJump
   } state_e;

   state_e          state_q, state_d;
   logic [TO_W-1:0] stall_q, stall_d;
   logic            at_limit;

   assign at_limit = (stall_q == StallLimit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StInit;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      stall_d           = '0;
      bus.PC_write      = 1'b0;
      bus.PC_write_cond = 1'b0;
      bus.I_or_D        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.IR_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.ALU_src_A     = 1'b0;
      bus.ALU_src_B     = 2'b00;
      bus.ALU_op        = 2'b00;
      bus.PC_source     = 2'b00;
      bus.illegal_op    = 1'b0;
      bus.bus_error     = 1'b0;

      case (state_q)
         StInit: begin
            state_d = StFetch;
         end

         StFetch: begin
            bus.mem_read  = 1'b1;
            bus.ALU_src_B = 2'b01;
            bus.IR_write  = bus.mem_ready;
            bus.PC_write  = bus.mem_ready;
            if (bus.mem_ready) begin
               state_d = StDecode;
            end else if (at_limit) begin
               // A fetch that never completes restarts the whole controller.
               bus.bus_error = 1'b1;
               state_d       = StInit;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end

         StDecode: begin
            // ALU precomputes the branch target while the opcode is decoded.
            bus.ALU_src_B = 2'b11;
            case (bus.opcode)
               OpLw, OpSw: state_d = StMemAddr;
               OpRType:    state_d = StRExec;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiExec;
               default: begin
                  bus.illegal_op = 1'b1;
                  state_d        = StFetch;
               end
            endcase
         end

         StMemAddr: begin
            bus.ALU_src_A = 1'b1;
            bus.ALU_src_B = 2'b10;
            state_d       = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
         end

         StMemRead: begin
            bus.mem_read = 1'b1;
            bus.I_or_D   = 1'b1;
            if (bus.mem_ready) begin
               state_d = StMemWb;
            end else if (at_limit) begin
               bus.bus_error = 1'b1;
               state_d       = StFetch;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end

         StMemWb: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            state_d        = StFetch;
         end

         StMemWrite: begin
            bus.mem_write = 1'b1;
            bus.I_or_D    = 1'b1;
            if (bus.mem_ready) begin
               state_d = StFetch;
            end else if (at_limit) begin
               bus.bus_error = 1'b1;
               state_d       = StFetch;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end

         StRExec: begin
            bus.ALU_src_A = 1'b1;
            bus.ALU_op    = 2'b10;
            state_d       = StRWb;
         end

         StRWb: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            state_d       = StFetch;
         end

         StAddiExec: begin
            bus.ALU_src_A = 1'b1;
            bus.ALU_src_B = 2'b10;
            state_d       = StAddiWb;
         end

         StAddiWb: begin
            bus.reg_write = 1'b1;
            state_d       = StFetch;
         end

         StBranch: begin
            bus.ALU_src_A     = 1'b1;
            bus.ALU_op        = 2'b01;
            bus.PC_write_cond = 1'b1;
            bus.PC_source     = 2'b01;
            state_d           = StFetch;
         end

         StJump: begin
            bus.PC_write  = 1'b1;
            bus.PC_source = 2'b10;
            state_d       = StFetch;
         end

         default: begin
            state_d = StInit;
         end
      endcase
   end

endmodule
